cpu65xx_microsequencer: RTL and testbench
=========================================

// Module: cpu65xx_microsequencer
// PURPOSE
//  Parametrised microprogram sequencer for the 65xx cores. Each enabled cycle it computes the next
//  microcode ROM address from the current microinstruction's sequencer fields, condition flags, the
//  fetched opcode and interrupt status. It adds a subroutine return stack, opcode dispatch and
//  interrupt dispatch, and sits between the microarchitecture datapath and the microcode ROM.
// PARAMETERS
//  UADDR_WIDTH    10    microcode address width
//  OPCODE_WIDTH   8     opcode width; must satisfy OPCODE_WIDTH <= UADDR_WIDTH
//  NUM_CONDS      8     number of condition inputs; >= 2
//  STACK_DEPTH    4     return-stack entries; >= 1
//  RESET_ADDR     0     microaddress loaded on reset and on stack underflow
//  IRQ_ADDR       1     microaddress of the interrupt entry routine
// PORTS
//  clock            in   1                    system clock
//  reset            in   1                    synchronous, active-high
//  enable           in   1                    clock enable; low = full stall
//  seqOp            in   3                    sequencer op of current microinstruction
//  seqBranchAddr    in   UADDR_WIDTH          branch/jump/call target
//  seqCondSel       in   $clog2(NUM_CONDS)    condition select
//  seqCondInvert    in   1                    invert selected condition
//  conditions       in   NUM_CONDS            datapath condition flags
//  opcode           in   OPCODE_WIDTH         latched opcode for dispatch
//  interruptPending in   1                    NMI/IRQ/RESET pending, from uArch
//  uCodeAddress     out  UADDR_WIDTH          registered ROM address
//  stackDepth       out  $clog2(STACK_DEPTH+1) live return-stack entries
//  stackOverflow    out  1                    sticky: CALL while stack full
//  stackUnderflow   out  1                    sticky: RETURN while stack empty
//  illegalOp        out  1                    sticky: seqOp==7 executed
// BEHAVIOUR
//  - Reset (priority over enable): uCodeAddress=RESET_ADDR, stackDepth=0, all sticky flags=0.
//  - enable low: all state held, including a pending update; no flag changes.
//  - Control inputs describe the microinstruction at the current uCodeAddress. The next address is
//    registered on the enabled edge, so there is 1 cycle latency from the inputs to uCodeAddress.
//  - inc = uCodeAddress+1 mod 2^UADDR_WIDTH; the max address wraps to 0.
//  - dispatch = opcode << (UADDR_WIDTH-OPCODE_WIDTH), with zero-filled low bits.
//  - cond = conditions[seqCondSel] ^ seqCondInvert; a seqCondSel >= NUM_CONDS reads as 0.
//  - seqOp encodings:
//    0 NEXT     -> inc
//    1 JUMP     -> seqBranchAddr
//    2 BRANCH   -> cond ? seqBranchAddr : inc
//    3 CALL     -> push inc, then seqBranchAddr
//    4 RETURN   -> pop top of stack
//    5 DISPATCH -> dispatch
//    6 DISPIRQ  -> interruptPending ? IRQ_ADDR : dispatch
//    7 illegal  -> inc, and set illegalOp
//  - The stack is circular storage with a top pointer; stackDepth saturates at STACK_DEPTH.
//  - CALL when depth==STACK_DEPTH: the jump is still taken and the oldest entry is overwritten
//    (wrap). Depth stays STACK_DEPTH and stackOverflow is set.
//  - RETURN when depth==0: next=RESET_ADDR, the pointer is unchanged and stackUnderflow is set.
//  - The stack is read and written only on CALL or RETURN with enable high.
//  - Sticky flags clear only on reset.
//  - Reset asserted mid-subroutine: the stack is discarded (depth 0) and the next address is
//    RESET_ADDR.
// TESTING
//  1. Reset, then 3 cycles of NEXT -> uCodeAddress 0,1,2,3; then stall enable 5 cycles -> holds 3.
//  2. BRANCH with conditions=8'h04, condSel=2, inv=0, target 0x155 -> 0x155; with inv=1 -> inc.
//  3. DISPATCH with opcode=0xA9 (W=10) -> 0x2A4. DISPIRQ with pending=1 -> IRQ_ADDR; pending=0 -> 0x2A4.
//  4. Nested CALLs from 0x010/0x020/0x030 (targets 0x020/0x030/0x040), then 3 RETURNs -> 0x031,
//     0x021, 0x011; stackDepth goes 1,2,3,2,1,0.
//  5. 5 CALLs with STACK_DEPTH=4 -> overflow set and depth 4; the 4 RETURNs give the newest four
//     returns; a 5th RETURN -> RESET_ADDR with underflow set.
//  6. At address 0x3FF do NEXT -> 0x000. Execute seqOp 7 -> illegalOp set. Reset during CALL depth
//     2 -> address 0, depth 0, all flags 0.

Source files
------------

// File: rtl/cpu65xx_microsequencer.sv
// Microprogram sequencer for the 65xx cores: computes the next microcode ROM address from
// sequencer fields, condition flags, opcode dispatch, interrupt status and a return stack.
module cpu65xx_microsequencer #(
    parameter int unsigned UADDR_WIDTH  = 10,
    parameter int unsigned OPCODE_WIDTH = 8,
    parameter int unsigned NUM_CONDS    = 8,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned RESET_ADDR   = 0,
    parameter int unsigned IRQ_ADDR     = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [2:0]                         seqOp,
    input  logic [UADDR_WIDTH-1:0]             seqBranchAddr,
    input  logic [$clog2(NUM_CONDS)-1:0]       seqCondSel,
    input  logic                               seqCondInvert,
    input  logic [NUM_CONDS-1:0]               conditions,
    input  logic [OPCODE_WIDTH-1:0]            opcode,
    input  logic                               interruptPending,
    output logic [UADDR_WIDTH-1:0]             uCodeAddress,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stackDepth,
    output logic                               stackOverflow,
    output logic                               stackUnderflow,
    output logic                               illegalOp
);

    localparam int unsigned SEL_W   = $clog2(NUM_CONDS);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SHIFT   = UADDR_WIDTH - OPCODE_WIDTH;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRANCH   = 3'd2;
    localparam logic [2:0] OP_CALL     = 3'd3;
    localparam logic [2:0] OP_RETURN   = 3'd4;
    localparam logic [2:0] OP_DISPATCH = 3'd5;
    localparam logic [2:0] OP_DISPIRQ  = 3'd6;

    logic [UADDR_WIDTH-1:0] r_addr;
    logic [DEPTH_W-1:0]     r_depth;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   r_illegal;
    logic [UADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [UADDR_WIDTH-1:0] w_inc;
    logic [UADDR_WIDTH-1:0] w_dispatch;
    logic [UADDR_WIDTH-1:0] w_next;
    logic [PTR_W-1:0]       w_ptr_inc;
    logic [PTR_W-1:0]       w_ptr_dec;
    logic                   w_cond;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_illegal;
    logic                   w_full;
    logic                   w_empty;

    // r_ptr names the next free slot; when full it also names the oldest entry
    assign w_ptr_inc  = (r_ptr == PTR_W'(STACK_DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec  = (r_ptr == '0) ? PTR_W'(STACK_DEPTH - 1) : r_ptr - PTR_W'(1);
    assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_inc      = r_addr + UADDR_WIDTH'(1);
    assign w_dispatch = UADDR_WIDTH'(opcode) << SHIFT;
    assign w_cond     = ((32'(seqCondSel) < NUM_CONDS) ? conditions[seqCondSel] : 1'b0)
                        ^ seqCondInvert;

    // Next-address selection and stack/flag requests
    always_comb begin
        w_next    = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_illegal = 1'b0;
        case (seqOp)
            OP_NEXT:     w_next = w_inc;
            OP_JUMP:     w_next = seqBranchAddr;
            OP_BRANCH:   w_next = w_cond ? seqBranchAddr : w_inc;
            OP_CALL: begin
                w_next = seqBranchAddr;
                w_push = 1'b1;
            end
            OP_RETURN: begin
                w_next = w_empty ? UADDR_WIDTH'(RESET_ADDR) : r_stack[w_ptr_dec];
                w_pop  = 1'b1;
            end
            OP_DISPATCH: w_next = w_dispatch;
            OP_DISPIRQ:  w_next = interruptPending ? UADDR_WIDTH'(IRQ_ADDR) : w_dispatch;
            default: begin
                w_next    = w_inc;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= UADDR_WIDTH'(RESET_ADDR);
            r_depth     <= '0;
            r_ptr       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (enable) begin
            r_addr <= w_next;
            if (w_push) begin
                r_stack[r_ptr] <= w_inc;
                r_ptr          <= w_ptr_inc;
                if (w_full) r_overflow <= 1'b1;
                else        r_depth    <= r_depth + DEPTH_W'(1);
            end
            if (w_pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_depth <= r_depth - DEPTH_W'(1);
                    r_ptr   <= w_ptr_dec;
                end
            end
            if (w_illegal) r_illegal <= 1'b1;
        end
    end

    assign uCodeAddress   = r_addr;
    assign stackDepth     = r_depth;
    assign stackOverflow  = r_overflow;
    assign stackUnderflow = r_underflow;
    assign illegalOp      = r_illegal;

endmodule

// File: tb/tb_cpu65xx_microsequencer.sv
// Scoreboard bench for cpu65xx_microsequencer: each step queues the expected address, depth and
// sticky flags {overflow,underflow,illegal}; each scenario drains the queue against captured outputs.
module tb_cpu65xx_microsequencer;

    typedef struct packed {
        logic [9:0] addr;
        logic [2:0] depth;
        logic [2:0] flags;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] seqOp;
    logic [9:0] seqBranchAddr;
    logic [2:0] seqCondSel;
    logic       seqCondInvert;
    logic [7:0] conditions;
    logic [7:0] opcode;
    logic       interruptPending;
    logic [9:0] uCodeAddress;
    logic [2:0] stackDepth;
    logic       stackOverflow;
    logic       stackUnderflow;
    logic       illegalOp;

    obs_t  sb_exp[$];
    obs_t  sb_got[$];
    string sb_name[$];
    int    errors = 0;
    int    checks = 0;

    cpu65xx_microsequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .seqOp(seqOp),
        .seqBranchAddr(seqBranchAddr), .seqCondSel(seqCondSel), .seqCondInvert(seqCondInvert),
        .conditions(conditions), .opcode(opcode), .interruptPending(interruptPending),
        .uCodeAddress(uCodeAddress), .stackDepth(stackDepth), .stackOverflow(stackOverflow),
        .stackUnderflow(stackUnderflow), .illegalOp(illegalOp)
    );

    always #5 clock = ~clock;

    // Drive one cycle: queue the expectation, clock, capture the outputs 1ns after the edge
    task automatic step(input logic [2:0] op, input logic [9:0] br, input logic en,
                        input logic [9:0] ea, input logic [2:0] ed, input logic [2:0] ef,
                        input string nm);
        seqOp = op;
        seqBranchAddr = br;
        enable = en;
        sb_exp.push_back('{addr: ea, depth: ed, flags: ef});
        sb_name.push_back(nm);
        @(posedge clock);
        #1;
        sb_got.push_back('{addr: uCodeAddress, depth: stackDepth,
                           flags: {stackOverflow, stackUnderflow, illegalOp}});
        reset = 1'b0;
    endtask

    task automatic test_reset;
        obs_t e, g;
        string n;
        reset = 1'b1;
        step(3'd1, 10'h2AA, 1'b1, 10'h000, 3'd0, 3'b000, "reset");
        step(3'd0, 10'h000, 1'b1, 10'h001, 3'd0, 3'b000, "next1");
        step(3'd0, 10'h000, 1'b1, 10'h002, 3'd0, 3'b000, "next2");
        step(3'd0, 10'h000, 1'b1, 10'h003, 3'd0, 3'b000, "next3");
        // Stalled cycles carry live ops (including illegal) that must have no effect
        step(3'd1, 10'h123, 1'b0, 10'h003, 3'd0, 3'b000, "stall_jump");
        step(3'd7, 10'h000, 1'b0, 10'h003, 3'd0, 3'b000, "stall_illegal");
        step(3'd3, 10'h050, 1'b0, 10'h003, 3'd0, 3'b000, "stall_call");
        step(3'd4, 10'h000, 1'b0, 10'h003, 3'd0, 3'b000, "stall_return");
        step(3'd0, 10'h000, 1'b0, 10'h003, 3'd0, 3'b000, "stall_next");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); g = sb_got.pop_front(); n = sb_name.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h depth=%0d flags=%b, expected addr=%h depth=%0d flags=%b",
                         n, g.addr, g.depth, g.flags, e.addr, e.depth, e.flags);
            end
        end
    endtask

    task automatic test_branch;
        obs_t e, g;
        string n;
        conditions = 8'h04;
        seqCondSel = 3'd2;
        seqCondInvert = 1'b0;
        step(3'd2, 10'h155, 1'b1, 10'h155, 3'd0, 3'b000, "branch_taken");
        seqCondInvert = 1'b1;
        step(3'd2, 10'h200, 1'b1, 10'h156, 3'd0, 3'b000, "branch_inv_not_taken");
        seqCondSel = 3'd1;
        step(3'd2, 10'h077, 1'b1, 10'h077, 3'd0, 3'b000, "branch_inv_clear_taken");
        seqCondInvert = 1'b0;
        step(3'd2, 10'h300, 1'b1, 10'h078, 3'd0, 3'b000, "branch_clear_not_taken");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); g = sb_got.pop_front(); n = sb_name.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h depth=%0d flags=%b, expected addr=%h depth=%0d flags=%b",
                         n, g.addr, g.depth, g.flags, e.addr, e.depth, e.flags);
            end
        end
    endtask

    task automatic test_dispatch;
        obs_t e, g;
        string n;
        opcode = 8'hA9;
        interruptPending = 1'b1;
        step(3'd5, 10'h000, 1'b1, 10'h2A4, 3'd0, 3'b000, "dispatch");
        step(3'd6, 10'h000, 1'b1, 10'h001, 3'd0, 3'b000, "dispirq_pending");
        interruptPending = 1'b0;
        step(3'd6, 10'h000, 1'b1, 10'h2A4, 3'd0, 3'b000, "dispirq_idle");
        opcode = 8'hFF;
        step(3'd5, 10'h000, 1'b1, 10'h3FC, 3'd0, 3'b000, "dispatch_ff");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); g = sb_got.pop_front(); n = sb_name.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h depth=%0d flags=%b, expected addr=%h depth=%0d flags=%b",
                         n, g.addr, g.depth, g.flags, e.addr, e.depth, e.flags);
            end
        end
    endtask

    task automatic test_nested_calls;
        obs_t e, g;
        string n;
        step(3'd1, 10'h010, 1'b1, 10'h010, 3'd0, 3'b000, "jump_010");
        step(3'd3, 10'h020, 1'b1, 10'h020, 3'd1, 3'b000, "call1");
        step(3'd3, 10'h099, 1'b0, 10'h020, 3'd1, 3'b000, "call_stalled");
        step(3'd3, 10'h030, 1'b1, 10'h030, 3'd2, 3'b000, "call2");
        step(3'd3, 10'h040, 1'b1, 10'h040, 3'd3, 3'b000, "call3");
        step(3'd4, 10'h000, 1'b1, 10'h031, 3'd2, 3'b000, "ret3");
        step(3'd4, 10'h000, 1'b1, 10'h021, 3'd1, 3'b000, "ret2");
        step(3'd4, 10'h000, 1'b1, 10'h011, 3'd0, 3'b000, "ret1");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); g = sb_got.pop_front(); n = sb_name.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h depth=%0d flags=%b, expected addr=%h depth=%0d flags=%b",
                         n, g.addr, g.depth, g.flags, e.addr, e.depth, e.flags);
            end
        end
    endtask

    task automatic test_overflow;
        obs_t e, g;
        string n;
        logic [9:0] a;
        reset = 1'b1;
        step(3'd0, 10'h000, 1'b1, 10'h000, 3'd0, 3'b000, "reset2");
        step(3'd1, 10'h100, 1'b1, 10'h100, 3'd0, 3'b000, "jump_100");
        // Calls from 0x100,0x110,...,0x140 push 0x101,0x111,...,0x141; the fifth overwrites the oldest
        for (int i = 1; i <= 5; i++) begin
            a = 10'h100 + 10'(16 * i);
            step(3'd3, a, 1'b1, a, (i > 4) ? 3'd4 : 3'(i), (i > 4) ? 3'b100 : 3'b000, "call_ovf");
        end
        for (int i = 4; i >= 1; i--) begin
            a = 10'h101 + 10'(16 * i);
            step(3'd4, 10'h000, 1'b1, a, 3'(i - 1), 3'b100, "ret_ovf");
        end
        step(3'd4, 10'h000, 1'b1, 10'h000, 3'd0, 3'b110, "ret_underflow");
        step(3'd0, 10'h000, 1'b1, 10'h001, 3'd0, 3'b110, "flags_sticky");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); g = sb_got.pop_front(); n = sb_name.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h depth=%0d flags=%b, expected addr=%h depth=%0d flags=%b",
                         n, g.addr, g.depth, g.flags, e.addr, e.depth, e.flags);
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t e, g;
        string n;
        reset = 1'b1;
        step(3'd0, 10'h000, 1'b1, 10'h000, 3'd0, 3'b000, "reset3");
        step(3'd1, 10'h3FF, 1'b1, 10'h3FF, 3'd0, 3'b000, "jump_3ff");
        step(3'd0, 10'h000, 1'b1, 10'h000, 3'd0, 3'b000, "wrap_to_0");
        step(3'd7, 10'h155, 1'b1, 10'h001, 3'd0, 3'b001, "illegal_op");
        step(3'd3, 10'h080, 1'b1, 10'h080, 3'd1, 3'b001, "call_a");
        step(3'd3, 10'h090, 1'b1, 10'h090, 3'd2, 3'b001, "call_b");
        // Reset wins over a stalled CALL and discards the stack
        reset = 1'b1;
        step(3'd3, 10'h0A0, 1'b0, 10'h000, 3'd0, 3'b000, "reset_mid_call");
        step(3'd4, 10'h000, 1'b1, 10'h000, 3'd0, 3'b010, "ret_after_reset");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); g = sb_got.pop_front(); n = sb_name.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h depth=%0d flags=%b, expected addr=%h depth=%0d flags=%b",
                         n, g.addr, g.depth, g.flags, e.addr, e.depth, e.flags);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        seqOp = 3'd0;
        seqBranchAddr = '0;
        seqCondSel = '0;
        seqCondInvert = 1'b0;
        conditions = '0;
        opcode = '0;
        interruptPending = 1'b0;
        #2;
        test_reset;
        test_branch;
        test_dispatch;
        test_nested_calls;
        test_overflow;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
